// File: rtl/gs_dram_port_if.sv
// Signal bundle between gs_dram_port and its client, ROM loader and memory backend.
// Backend command handshake: a command transfers on a rising edge where M_VALID and M_READY are both 1; while M_VALID is 1 and M_READY is 0 the command fields do not change.
interface gs_dram_port_if;
    logic        REQ;
    logic        RNW;
    logic [23:0] ADDR;
    logic [1:0]  BSEL;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        ACK;
    logic        LD_WR;
    logic [23:0] LD_ADDR;
    logic [15:0] LD_DATA;
    logic [1:0]  LD_BSEL;
    logic        LD_BUSY;
    logic        M_VALID;
    logic        M_READY;
    logic        M_WE;
    logic [23:0] M_ADDR;
    logic [1:0]  M_BE;
    logic [15:0] M_WDATA;
    logic        M_RVALID;
    logic [15:0] M_RDATA;
    logic        ERR;
    logic        OVF;
    logic [1:0]  dbg_state;

    modport slave (
        input  REQ, RNW, ADDR, BSEL, DI, LD_WR, LD_ADDR, LD_DATA, LD_BSEL,
               M_READY, M_RVALID, M_RDATA,
        output DO, ACK, LD_BUSY, M_VALID, M_WE, M_ADDR, M_BE, M_WDATA, ERR, OVF,
               dbg_state
    );

    modport master (
        output REQ, RNW, ADDR, BSEL, DI, LD_WR, LD_ADDR, LD_DATA, LD_BSEL,
               M_READY, M_RVALID, M_RDATA,
        input  DO, ACK, LD_BUSY, M_VALID, M_WE, M_ADDR, M_BE, M_WDATA, ERR, OVF,
               dbg_state
    );
endinterface

// File: rtl/gs_dram_port.sv
// Single-client DRAM port with a one-entry ROM-preload buffer, a backend command
// handshake and a per-command timeout. All outputs come straight from flops.
module gs_dram_port #(
    parameter int TIMEOUT = 255
) (
    input logic           CLK,
    input logic           RESET_n,
    gs_dram_port_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WAIT_RD = 2'd2, DONE = 2'd3} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic        m_valid_q, m_valid_d;
    logic        m_we_q, m_we_d;
    logic [23:0] m_addr_q, m_addr_d;
    logic [1:0]  m_be_q, m_be_d;
    logic [15:0] m_wdata_q, m_wdata_d;
    logic [15:0] do_q, do_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rnw_q, rnw_d;
    logic        is_ld_q, is_ld_d;
    logic        ld_full_q, ld_full_d;
    logic [23:0] ld_addr_q, ld_addr_d;
    logic [15:0] ld_data_q, ld_data_d;
    logic [1:0]  ld_bsel_q, ld_bsel_d;
    logic        cnt_last, ld_accept, ld_expire;

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        m_valid_d = m_valid_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_be_d    = m_be_q;
        m_wdata_d = m_wdata_q;
        do_d      = do_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        rnw_d     = rnw_q;
        is_ld_d   = is_ld_q;
        ld_full_d = ld_full_q;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        ld_bsel_d = ld_bsel_q;

        cnt_last  = (cnt_q == TMO_LAST);
        ld_accept = (state_q == CMD) && is_ld_q && bus.M_READY;
        ld_expire = (state_q == CMD) && is_ld_q && !bus.M_READY && cnt_last;

        // The buffer frees on the same edge its entry leaves, so a strobe there is kept.
        if (bus.LD_WR) begin
            if (!ld_full_q || ld_accept || ld_expire) begin
                ld_full_d = 1'b1;
                ld_addr_d = bus.LD_ADDR;
                ld_data_d = bus.LD_DATA;
                ld_bsel_d = bus.LD_BSEL;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ld_accept || ld_expire) begin
            ld_full_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ld_full_q || bus.LD_WR) begin
                    m_valid_d = 1'b1;
                    m_we_d    = 1'b1;
                    m_addr_d  = ld_full_q ? ld_addr_q : bus.LD_ADDR;
                    m_be_d    = ld_full_q ? ld_bsel_q : bus.LD_BSEL;
                    m_wdata_d = ld_full_q ? ld_data_q : bus.LD_DATA;
                    is_ld_d   = 1'b1;
                    rnw_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = CMD;
                end else if (bus.REQ) begin
                    is_ld_d = 1'b0;
                    rnw_d   = bus.RNW;
                    if (bus.RNW) begin
                        m_valid_d = 1'b1;
                        m_we_d    = 1'b0;
                        m_addr_d  = bus.ADDR;
                        m_be_d    = 2'b11;
                        cnt_d     = '0;
                        state_d   = CMD;
                    end else if (bus.BSEL == 2'b00) begin
                        // Nothing to write: acknowledge without touching the backend.
                        state_d = DONE;
                    end else begin
                        m_valid_d = 1'b1;
                        m_we_d    = 1'b1;
                        m_addr_d  = bus.ADDR;
                        m_be_d    = bus.BSEL;
                        m_wdata_d = bus.DI;
                        cnt_d     = '0;
                        state_d   = CMD;
                    end
                end
            end
            CMD: begin
                if (bus.M_READY || cnt_last) begin
                    m_valid_d = 1'b0;
                    err_d     = err_q | ~bus.M_READY;
                    if (is_ld_q) begin
                        state_d = IDLE;
                    end else if (rnw_q && bus.M_READY) begin
                        cnt_d   = '0;
                        state_d = WAIT_RD;
                    end else begin
                        if (rnw_q) do_d = 16'hFFFF;
                        ack_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_RD: begin
                if (bus.M_RVALID) begin
                    do_d    = bus.M_RDATA;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_last) begin
                    err_d   = 1'b1;
                    do_d    = 16'hFFFF;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                // A zero-byte write arrives here with ACK still low and pulses it one cycle later.
                if (ack_q) state_d = IDLE;
                else ack_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= '0;
            m_wdata_q <= '0;
            do_q      <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            rnw_q     <= 1'b0;
            is_ld_q   <= 1'b0;
            ld_full_q <= 1'b0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
            ld_bsel_q <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            m_valid_q <= m_valid_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_be_q    <= m_be_d;
            m_wdata_q <= m_wdata_d;
            do_q      <= do_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            rnw_q     <= rnw_d;
            is_ld_q   <= is_ld_d;
            ld_full_q <= ld_full_d;
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
            ld_bsel_q <= ld_bsel_d;
        end
    end

    assign bus.ACK       = ack_q;
    assign bus.DO        = do_q;
    assign bus.LD_BUSY   = ld_full_q;
    assign bus.M_VALID   = m_valid_q;
    assign bus.M_WE      = m_we_q;
    assign bus.M_ADDR    = m_addr_q;
    assign bus.M_BE      = m_be_q;
    assign bus.M_WDATA   = m_wdata_q;
    assign bus.ERR       = err_q;
    assign bus.OVF       = ovf_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/gs_dram_port.md
GS_DRAM_PORT -- requirements
Module: gs_dram_port

Interface
REQ-001 Parameter TIMEOUT, default 255, backend wait limit in cycles (1..255).
REQ-002 Ports, in order:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- REQ  in  1  client request level, held until ACK.
- RNW  in  1  client 1=read, 0=write.
- ADDR  in  24  client word address.
- BSEL  in  2  client byte selects, bit1=high byte.
- DI  in  16  client write data.
- DO  out  16  client read data.
- ACK  out  1  one-cycle completion pulse.
- LD_WR  in  1  loader write strobe (ROM preload).
- LD_ADDR  in  24  loader word address.
- LD_DATA  in  16  loader data.
- LD_BSEL  in  2  loader byte selects.
- LD_BUSY  out  1  loader buffer occupied.
- M_VALID  out  1  backend command valid.
- M_READY  in  1  backend command accept.
- M_WE  out  1  backend write enable.
- M_ADDR  out  24  backend address.
- M_BE  out  2  backend byte enables.
- M_WDATA  out  16  backend write data.
- M_RVALID  in  1  backend read data valid.
- M_RDATA  in  16  backend read data.
- ERR  out  1  sticky timeout flag.
- OVF  out  1  sticky loader overflow flag.

Function
REQ-003 FSM states: IDLE, CMD, WAIT_RD, DONE; all outputs registered.
REQ-004 IDLE: a pending loader entry wins over REQ; it is latched into M_* with M_WE=1, then CMD.
REQ-005 IDLE with REQ=1 and no loader entry: latch ADDR/BSEL/DI/RNW, then CMD.
- Read: M_WE=0, M_BE=2'b11.
- Write: M_WE=1, M_BE=BSEL, M_WDATA=DI.
REQ-006 Client write with BSEL=2'b00: no backend command; go straight to DONE.
REQ-007 CMD: M_VALID=1 until the cycle with M_READY=1; M_ADDR/M_BE/M_WDATA/M_WE stay stable while M_VALID=1.
REQ-008 On the accept edge, M_VALID drops; next state is:
- WAIT_RD for a client read;
- DONE for a client write;
- IDLE for a loader write (no ACK).
REQ-009 WAIT_RD: on M_RVALID=1, DO<=M_RDATA, then DONE.
REQ-010 DONE: ACK=1 for exactly one cycle; next IDLE. REQ is not sampled in DONE.
REQ-011 Minimum latency, REQ seen at edge 0:
- Write, M_READY tied high: M_VALID in cycle 1, ACK in cycle 2.
- Read, M_RVALID one cycle after accept: ACK in cycle 3 with DO valid.
REQ-012 DO holds its value from a read ACK until the next read completion; writes never change DO.
REQ-013 Loader buffer: one entry.
- LD_WR=1 with buffer empty stores the entry; LD_BUSY=1 from the next cycle until that entry is accepted by the backend.
- LD_WR=1 while LD_BUSY=1 drops the new entry and sets OVF.
- LD_WR in the same cycle the entry is accepted is stored, not dropped.
REQ-014 Timeout counter:
- Cleared on entering CMD or WAIT_RD; counts each cycle in those states.
- On reaching TIMEOUT: set ERR and drop M_VALID.
- Client read goes to DONE with DO=16'hFFFF; client write goes to DONE; loader write goes to IDLE.
REQ-015 M_RVALID outside WAIT_RD is ignored, including late data after a timeout.
REQ-016 REQ dropping mid-transaction does not abort; the operation completes and ACK still pulses.
REQ-017 ERR and OVF clear only on reset.

Reset
REQ-018 RESET_n=0 forces immediately:
- state IDLE;
- ACK, M_VALID, M_WE, LD_BUSY, ERR, OVF = 0;
- DO, M_ADDR, M_BE, M_WDATA, timeout counter = 0;
- loader buffer empty.
REQ-019 Reset mid-transaction abandons it without ACK; the first REQ after RESET_n rises is served normally.

Verification
REQ-020 Read ADDR=24'h400010, M_READY=1, M_RVALID one cycle later with M_RDATA=16'hA55A -> M_VALID cycle 1, ACK cycle 3, DO=16'hA55A held after ACK.
REQ-021 Write BSEL=2'b10, DI=16'h1234, M_READY low 3 cycles -> M_VALID held 4 cycles with M_BE=2'b10 and M_WDATA=16'h1234 stable; single ACK pulse; DO unchanged.
REQ-022 LD_WR and REQ in same cycle, then a second LD_WR while LD_BUSY=1 -> loader write issued first with no ACK, client served next, OVF=1, second loader entry never on M_*.
REQ-023 TIMEOUT=8, read with M_READY=1 and no M_RVALID -> ACK 8 cycles after entering WAIT_RD, DO=16'hFFFF, ERR=1; later M_RVALID ignored.
REQ-024 Write BSEL=2'b00 -> ACK in cycle 2, M_VALID never asserted.
REQ-025 RESET_n low while in WAIT_RD -> all outputs at reset values asynchronously; no ACK; a subsequent read completes per REQ-020.
